// File: rtl/fe_branch_predictor.sv
// Fetch-stage gshare direction predictor with a direct-mapped BTB.
// Lookup is purely combinational; training arrives from AGEX and lands on the rising clock edge.
module fe_branch_predictor #(
   parameter int DBITS        = 32,
   parameter int PHT_IDX_BITS = 10,
   parameter int BHR_BITS     = 8,
   parameter int BTB_IDX_BITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DBITS-1:0]        lookup_pc,
   input  logic [DBITS-1:0]        lookup_pcplus,
   output logic [DBITS-1:0]        pred_pc,
   output logic                    pred_taken,
   output logic                    pred_btb_hit,
   output logic [PHT_IDX_BITS-1:0] pred_pht_index,
   input  logic                    upd_valid,
   input  logic                    upd_taken,
   input  logic [DBITS-1:0]        upd_pc,
   input  logic [DBITS-1:0]        upd_target,
   input  logic [PHT_IDX_BITS-1:0] upd_pht_index,
   input  logic                    upd_mispred,
   output logic [31:0]             stat_updates,
   output logic [31:0]             stat_mispreds
);

   localparam int PHT_SIZE = 1 << PHT_IDX_BITS;
   localparam int BTB_SIZE = 1 << BTB_IDX_BITS;
   localparam int TAG_BITS = DBITS - BTB_IDX_BITS - 2;

   logic [1:0]              pht_q [PHT_SIZE];
   logic [BHR_BITS-1:0]     bhr_q, bhr_d;
   logic                    btbValid_q [BTB_SIZE];
   logic [TAG_BITS-1:0]     btbTag_q [BTB_SIZE];
   logic [DBITS-1:0]        btbTarget_q [BTB_SIZE];
   logic [31:0]             statUpdates_q, statUpdates_d;
   logic [31:0]             statMispreds_q, statMispreds_d;
   logic [1:0]              phtCnt_d;

   logic [BTB_IDX_BITS-1:0] lookupBtbIdx;
   logic [TAG_BITS-1:0]     lookupTag;
   logic [BTB_IDX_BITS-1:0] updBtbIdx;
   logic [TAG_BITS-1:0]     updTag;
   logic                    unusedPcBits;

   assign lookupBtbIdx = lookup_pc[BTB_IDX_BITS+1:2];
   assign lookupTag    = lookup_pc[DBITS-1:BTB_IDX_BITS+2];
   assign updBtbIdx    = upd_pc[BTB_IDX_BITS+1:2];
   assign updTag       = upd_pc[DBITS-1:BTB_IDX_BITS+2];
   assign unusedPcBits = ^{lookup_pc[1:0], upd_pc[1:0]};

   // Lookup reads registered state only, so a same-cycle update is never visible here.
   assign pred_pht_index = lookup_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(bhr_q);
   assign pred_btb_hit   = btbValid_q[lookupBtbIdx] && (btbTag_q[lookupBtbIdx] == lookupTag);
   assign pred_taken     = pred_btb_hit && pht_q[pred_pht_index][1];
   assign pred_pc        = pred_taken ? btbTarget_q[lookupBtbIdx] : lookup_pcplus;

   assign stat_updates  = statUpdates_q;
   assign stat_mispreds = statMispreds_q;

   always_comb begin
      phtCnt_d       = pht_q[upd_pht_index];
      bhr_d          = {bhr_q[BHR_BITS-2:0], upd_taken};
      statUpdates_d  = statUpdates_q + 32'd1;
      statMispreds_d = statMispreds_q + 32'(upd_mispred);
      if (upd_taken && (phtCnt_d != 2'b11)) begin
         phtCnt_d = phtCnt_d + 2'd1;
      end else if (!upd_taken && (phtCnt_d != 2'b00)) begin
         phtCnt_d = phtCnt_d - 2'd1;
      end
   end

   // Counters reset to weakly not-taken; the BTB only learns from taken resolutions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PHT_SIZE; i++) begin
            pht_q[i] <= 2'b01;
         end
         for (int i = 0; i < BTB_SIZE; i++) begin
            btbValid_q[i]  <= 1'b0;
            btbTag_q[i]    <= '0;
            btbTarget_q[i] <= '0;
         end
         bhr_q          <= '0;
         statUpdates_q  <= '0;
         statMispreds_q <= '0;
      end else if (upd_valid) begin
         pht_q[upd_pht_index] <= phtCnt_d;
         bhr_q                <= bhr_d;
         statUpdates_q        <= statUpdates_d;
         statMispreds_q       <= statMispreds_d;
         if (upd_taken) begin
            btbValid_q[updBtbIdx]  <= 1'b1;
            btbTag_q[updBtbIdx]    <= updTag;
            btbTarget_q[updBtbIdx] <= upd_target;
         end
      end
   end

endmodule

// File: tb/tb_fe_branch_predictor.sv
// Self-checking bench for fe_branch_predictor: a vector table for history/PHT basics,
// then hand-built sequences for saturation, BTB aliasing, same-cycle update and async reset.
module tb_fe_branch_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] lookup_pc, lookup_pcplus, pred_pc;
   logic        pred_taken, pred_btb_hit;
   logic [9:0]  pred_pht_index;
   logic        upd_valid, upd_taken, upd_mispred;
   logic [31:0] upd_pc, upd_target;
   logic [9:0]  upd_pht_index;
   logic [31:0] stat_updates, stat_mispreds;

   fe_branch_predictor dut (
      .clk(clk), .reset(reset),
      .lookup_pc(lookup_pc), .lookup_pcplus(lookup_pcplus),
      .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_btb_hit(pred_btb_hit),
      .pred_pht_index(pred_pht_index),
      .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_pht_index(upd_pht_index), .upd_mispred(upd_mispred),
      .stat_updates(stat_updates), .stat_mispreds(stat_mispreds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] lookupPc;
      logic        updValid, updTaken, updMispred;
      logic [31:0] updPc, updTarget;
      logic [9:0]  updIdx;
      logic [9:0]  expIdx;
      logic        expHit, expTaken;
      logic [31:0] expPc;
   } vec_t;

   typedef struct {
      string       name;
      logic [9:0]  idx;
      logic        hit, taken;
      logic [31:0] pc, upd, mis;
   } exp_t;

   exp_t        sb[$];
   int          passed = 0;
   int          total  = 0;
   logic [31:0] expUpd = 0;
   logic [31:0] expMis = 0;
   vec_t        table_v[12];

   function automatic vec_t mkVec(string name, logic [31:0] lpc,
                                  logic uv, logic ut, logic um, logic [31:0] upc,
                                  logic [31:0] utgt, logic [9:0] uidx,
                                  logic [9:0] eidx, logic ehit, logic etaken, logic [31:0] epc);
      vec_t v;
      v.name = name; v.lookupPc = lpc;
      v.updValid = uv; v.updTaken = ut; v.updMispred = um;
      v.updPc = upc; v.updTarget = utgt; v.updIdx = uidx;
      v.expIdx = eidx; v.expHit = ehit; v.expTaken = etaken; v.expPc = epc;
      return v;
   endfunction

   task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", what, act, req);
   endtask

   task automatic checkOutput();
      exp_t e;
      e = sb.pop_front();
      cmp({e.name, ".pht_index"}, 32'(pred_pht_index), 32'(e.idx));
      cmp({e.name, ".btb_hit"}, 32'(pred_btb_hit), 32'(e.hit));
      cmp({e.name, ".taken"}, 32'(pred_taken), 32'(e.taken));
      cmp({e.name, ".pred_pc"}, pred_pc, e.pc);
      cmp({e.name, ".stat_updates"}, stat_updates, e.upd);
      cmp({e.name, ".stat_mispreds"}, stat_mispreds, e.mis);
   endtask

   task automatic expectNow(input string name, input logic [9:0] idx, input logic hit,
                            input logic taken, input logic [31:0] pc);
      exp_t e;
      e.name = name; e.idx = idx; e.hit = hit; e.taken = taken; e.pc = pc;
      e.upd = expUpd; e.mis = expMis;
      sb.push_back(e);
      checkOutput();
   endtask

   // Inputs change on the falling edge so the next rising edge trains exactly once.
   task automatic applyStimulus(input vec_t v, input bit check);
      @(negedge clk);
      lookup_pc     = v.lookupPc;
      lookup_pcplus = v.lookupPc + 32'd4;
      upd_valid     = v.updValid;
      upd_taken     = v.updTaken;
      upd_mispred   = v.updMispred;
      upd_pc        = v.updPc;
      upd_target    = v.updTarget;
      upd_pht_index = v.updIdx;
      #1;
      if (check) expectNow(v.name, v.expIdx, v.expHit, v.expTaken, v.expPc);
      if (v.updValid) begin
         expUpd++;
         if (v.updMispred) expMis++;
      end
   endtask

   task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                        input logic [9:0] idx);
      applyStimulus(mkVec("train", 32'h0, 1'b1, taken, 1'b0, pc, tgt, idx, 10'h0, 1'b0, 1'b0, 32'h0), 1'b0);
   endtask

   task automatic lookupCheck(input string name, input logic [31:0] pc, input logic [9:0] idx,
                              input logic hit, input logic taken, input logic [31:0] ppc);
      applyStimulus(mkVec(name, pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 10'h0, idx, hit, taken, ppc), 1'b1);
   endtask

   // Steer history to 0xC5 so that lookup 0x300 lands on PHT entry 0x005.
   task automatic probeSat(input string name, input logic expTaken);
      logic [7:0] pat;
      pat = 8'b11000101;
      for (int i = 7; i >= 0; i--) train(32'h4, 32'h8, pat[i], 10'h3FF);
      lookupCheck(name, 32'h300, 10'h005, 1'b1, expTaken, expTaken ? 32'h400 : 32'h304);
   endtask

   initial begin
      reset = 1'b0;
      lookup_pc = 32'h100; lookup_pcplus = 32'h104;
      upd_valid = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
      upd_pc = '0; upd_target = '0; upd_pht_index = '0;

      table_v[0]  = mkVec("reset_lookup", 32'h100, 0, 0, 0, 32'h0,   32'h0,   10'h000, 10'h040, 0, 0, 32'h104);
      table_v[1]  = mkVec("train_first",  32'h100, 1, 1, 1, 32'h100, 32'h200, 10'h040, 10'h040, 0, 0, 32'h104);
      table_v[2]  = mkVec("after_train",  32'h100, 0, 0, 0, 32'h0,   32'h0,   10'h000, 10'h041, 1, 0, 32'h104);
      table_v[3]  = mkVec("hist_1",       32'h100, 1, 0, 0, 32'h104, 32'h108, 10'h3FF, 10'h041, 1, 0, 32'h104);
      table_v[4]  = mkVec("hist_2",       32'h100, 1, 0, 0, 32'h104, 32'h108, 10'h3FF, 10'h042, 1, 0, 32'h104);
      table_v[5]  = mkVec("hist_3",       32'h100, 1, 0, 1, 32'h104, 32'h108, 10'h3FF, 10'h044, 1, 0, 32'h104);
      table_v[6]  = mkVec("hist_4",       32'h100, 1, 0, 0, 32'h104, 32'h108, 10'h3FF, 10'h048, 1, 0, 32'h104);
      table_v[7]  = mkVec("hist_5",       32'h100, 1, 0, 0, 32'h104, 32'h108, 10'h3FF, 10'h050, 1, 0, 32'h104);
      table_v[8]  = mkVec("hist_6",       32'h100, 1, 0, 0, 32'h104, 32'h108, 10'h3FF, 10'h060, 1, 0, 32'h104);
      table_v[9]  = mkVec("hist_7",       32'h100, 1, 0, 0, 32'h104, 32'h108, 10'h3FF, 10'h000, 1, 0, 32'h104);
      table_v[10] = mkVec("hist_8",       32'h100, 1, 0, 0, 32'h104, 32'h108, 10'h3FF, 10'h0C0, 1, 0, 32'h104);
      table_v[11] = mkVec("pht_trained",  32'h100, 0, 0, 0, 32'h0,   32'h0,   10'h000, 10'h040, 1, 1, 32'h200);

      #2;
      expectNow("in_reset", 10'h040, 1'b0, 1'b0, 32'h104);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) applyStimulus(table_v[i], 1'b1);

      // Saturation at PHT entry 0x005 via pc 0x300.
      for (int i = 0; i < 4; i++) train(32'h300, 32'h400, 1'b1, 10'h005);
      probeSat("sat_4taken", 1'b1);
      train(32'h300, 32'h400, 1'b1, 10'h005);
      probeSat("sat_5taken", 1'b1);
      train(32'h300, 32'h304, 1'b0, 10'h005);
      probeSat("sat_down1", 1'b1);
      for (int i = 0; i < 4; i++) train(32'h300, 32'h304, 1'b0, 10'h005);
      probeSat("sat_5nt", 1'b0);
      train(32'h300, 32'h400, 1'b1, 10'h005);
      probeSat("sat_up1", 1'b0);
      train(32'h300, 32'h400, 1'b1, 10'h005);
      probeSat("sat_up2", 1'b1);

      // BTB alias: 0x100 then 0x140 share entry 0; eight takens leave BHR=0xFF, PHT[0x0AF]=11.
      train(32'h100, 32'h200, 1'b1, 10'h0AF);
      for (int i = 0; i < 7; i++) train(32'h140, 32'h500, 1'b1, 10'h0AF);
      lookupCheck("alias_100", 32'h100, 10'h0BF, 1'b0, 1'b0, 32'h104);
      lookupCheck("alias_300", 32'h300, 10'h03F, 1'b0, 1'b0, 32'h304);
      applyStimulus(mkVec("alias_140", 32'h140, 1, 0, 0, 32'h140, 32'h144, 10'h3FF,
                          10'h0AF, 1, 1, 32'h500), 1'b1);

      // Same-cycle taken update to the looked-up counter (01); lookup must see the old value.
      applyStimulus(mkVec("same_cycle", 32'h140, 1, 1, 0, 32'h14C, 32'h600, 10'h0AE,
                          10'h0AE, 1, 0, 32'h144), 1'b1);
      lookupCheck("next_cycle", 32'h14C, 10'h0AE, 1'b1, 1'b1, 32'h600);

      // Asynchronous reset between edges, with an update held during reset.
      applyStimulus(mkVec("pre_reset", 32'h14C, 0, 0, 0, 32'h0, 32'h0, 10'h0,
                          10'h0, 0, 0, 32'h0), 1'b0);
      #1;
      reset = 1'b0;
      expUpd = 0;
      expMis = 0;
      #1;
      expectNow("async_reset", 10'h053, 1'b0, 1'b0, 32'h150);
      upd_valid = 1'b1; upd_taken = 1'b1; upd_mispred = 1'b1;
      upd_pc = 32'h14C; upd_target = 32'h700; upd_pht_index = 10'h053;
      @(posedge clk);
      #1;
      expectNow("reset_edge", 10'h053, 1'b0, 1'b0, 32'h150);
      @(negedge clk);
      upd_valid = 1'b0;
      reset = 1'b1;
      lookupCheck("post_reset_14c", 32'h14C, 10'h053, 1'b0, 1'b0, 32'h150);
      lookupCheck("post_reset_140", 32'h140, 10'h050, 1'b0, 1'b0, 32'h144);

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
